// File: rtl/float_to_int32_pipe_pkg.sv
// Shared fp32 / int32 constants and stage payload types for the float-to-int converter.
package float_to_int32_pipe_pkg;

  localparam int          FP32_BIAS    = 127;
  localparam logic [7:0]  FP32_EXP_MAX = 8'd255;
  localparam logic [31:0] INT32_MAX    = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN    = 32'h8000_0000;

  localparam logic [1:0] RM_RNE = 2'd0;
  localparam logic [1:0] RM_RTZ = 2'd1;
  localparam logic [1:0] RM_RUP = 2'd2;
  localparam logic [1:0] RM_RDN = 2'd3;

  typedef enum logic [2:0] {NORMAL, ZERO, DENORM, INF, NAN} fp32_class_e;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] mant;
    fp32_class_e cls;
    logic [1:0]  rmode;
  } s1_t;

  typedef struct packed {
    logic        sign;
    logic [31:0] mag;
    logic        guard;
    logic        sticky;
    logic [1:0]  rmode;
    logic        invalid;
    logic        nan;
  } s2_t;

  typedef struct packed {
    logic [31:0] dout;
    logic        invalid;
    logic        inexact;
  } s3_t;

endpackage

// File: rtl/float_to_int32_pipe_shift_right_sticky24.sv
// Right shift of a 24-bit mantissa returning the guard bit and the OR of everything below it.
module shift_right_sticky24 (
  input  logic [23:0] val,
  input  logic [4:0]  amt,
  output logic [23:0] res,
  output logic        guard,
  output logic        sticky
);

  // 25 extra low bits so an amount of 25 still pushes every mantissa bit into sticky.
  logic [48:0] ext;

  assign ext    = {val, 25'b0} >> amt;
  assign res    = ext[48:25];
  assign guard  = ext[24];
  assign sticky = |ext[23:0];

endmodule

// File: rtl/float_to_int32_pipe.sv
// Three-stage fp32 -> int32 converter: unpack, align, then round/negate/saturate.
module float_to_int32_pipe
  import float_to_int32_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vldin,
  output logic        rdyin,
  input  logic [31:0] ain,
  input  logic [1:0]  rmode,
  output logic        vldout,
  input  logic        rdyout,
  output logic [31:0] dout,
  output logic        invalid,
  output logic        inexact
);

  // Handshake: a word moves on a rising edge when valid && ready on that side.
  // The whole pipe advances as one unit when the output slot is empty or being drained,
  // so rdyin equals advance and bubbles stay in place during a stall.
  logic advance;
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  s1_t  s1_q, s1_d, s1_n;
  s2_t  s2_q, s2_d, s2_n;
  s3_t  s3_q, s3_d, s3_n;

  logic [4:0]  rs_amt;
  logic [23:0] rs_res;
  logic        rs_guard, rs_sticky;
  logic [3:0]  ls_amt;
  logic        oor;
  logic        inc;
  logic [31:0] mag_r;

  assign advance = !v3_q || rdyout;
  assign rdyin   = advance;

  always_comb begin
    s1_n       = '0;
    s1_n.sign  = ain[31];
    s1_n.exp   = ain[30:23];
    s1_n.mant  = {ain[30:23] != 8'd0, ain[22:0]};
    s1_n.rmode = rmode;
    if (ain[30:23] == FP32_EXP_MAX) s1_n.cls = (ain[22:0] != 23'd0) ? NAN : INF;
    else if (ain[30:23] == 8'd0)    s1_n.cls = (ain[22:0] != 23'd0) ? DENORM : ZERO;
    else                            s1_n.cls = NORMAL;
  end

  // 150 = bias + 23: at or above it the mantissa moves left, below it right.
  always_comb begin
    if (s1_q.exp >= 8'd150)      rs_amt = 5'd0;
    else if (s1_q.exp <= 8'd125) rs_amt = 5'd25;
    else                         rs_amt = 5'(8'd150 - s1_q.exp);
    if (s1_q.exp >= 8'd150 && s1_q.exp <= 8'd158) ls_amt = 4'(s1_q.exp - 8'd150);
    else                                          ls_amt = 4'd0;
  end

  shift_right_sticky24 u_rshift (
    .val    (s1_q.mant),
    .amt    (rs_amt),
    .res    (rs_res),
    .guard  (rs_guard),
    .sticky (rs_sticky)
  );

  // -2^31 exactly is the only e == 31 value that still fits.
  assign oor = (s1_q.exp >= 8'd158) &&
               !(s1_q.sign && s1_q.exp == 8'd158 && s1_q.mant[22:0] == 23'd0);

  always_comb begin
    s2_n         = '0;
    s2_n.sign    = s1_q.sign;
    s2_n.rmode   = s1_q.rmode;
    s2_n.nan     = (s1_q.cls == NAN);
    s2_n.invalid = (s1_q.cls == NAN) || (s1_q.cls == INF) || oor;
    if (s1_q.exp >= 8'd150) begin
      s2_n.mag = {8'd0, s1_q.mant} << ls_amt;
    end else begin
      s2_n.mag    = {8'd0, rs_res};
      s2_n.guard  = rs_guard;
      s2_n.sticky = rs_sticky;
    end
  end

  always_comb begin
    case (s2_q.rmode)
      RM_RNE:  inc = s2_q.guard && (s2_q.sticky || s2_q.mag[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = !s2_q.sign && (s2_q.guard || s2_q.sticky);
      default: inc = s2_q.sign && (s2_q.guard || s2_q.sticky);
    endcase
    mag_r = s2_q.mag + {31'd0, inc};
    s3_n  = '0;
    if (s2_q.invalid) begin
      s3_n.dout    = (s2_q.nan || !s2_q.sign) ? INT32_MAX : INT32_MIN;
      s3_n.invalid = 1'b1;
    end else begin
      s3_n.dout    = s2_q.sign ? (~mag_r + 32'd1) : mag_r;
      s3_n.inexact = s2_q.guard || s2_q.sticky;
    end
  end

  always_comb begin
    v1_d = advance ? vldin : v1_q;
    v2_d = advance ? v1_q  : v2_q;
    v3_d = advance ? v2_q  : v3_q;
    s1_d = advance ? s1_n  : s1_q;
    s2_d = advance ? s2_n  : s2_q;
    s3_d = advance ? s3_n  : s3_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign vldout  = v3_q;
  assign dout    = s3_q.dout;
  assign invalid = s3_q.invalid;
  assign inexact = s3_q.inexact;

endmodule

// File: tb/tb_float_to_int32_pipe.sv
// Bench for float_to_int32_pipe: arithmetic reference model, scoreboard queue, directed and random traffic.
module tb_float_to_int32_pipe;

  logic        clk;
  logic        rst_n;
  logic        vldin;
  logic        rdyin;
  logic [31:0] ain;
  logic [1:0]  rmode;
  logic        vldout;
  logic        rdyout;
  logic [31:0] dout;
  logic        invalid;
  logic        inexact;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int emit_cnt = 0;
  bit lat_check = 0;
  bit rand_done = 0;

  logic [33:0] exp_q[$];
  int          lat_q[$];
  logic        hold_v = 0;
  logic [33:0] hold_d = '0;

  float_to_int32_pipe dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .vldin   (vldin),
    .rdyin   (rdyin),
    .ain     (ain),
    .rmode   (rmode),
    .vldout  (vldout),
    .rdyout  (rdyout),
    .dout    (dout),
    .invalid (invalid),
    .inexact (inexact)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference: value = mant * 2^(E-150); round the exact quotient/remainder pair.
  // Returns {invalid, inexact, dout}.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [1:0] rm);
    logic        sign;
    logic [7:0]  e8;
    logic [63:0] n, q, rem, half, r;
    int          k;
    logic        up;
    sign = a[31];
    e8   = a[30:23];
    if (e8 == 8'hFF)
      return {1'b1, 1'b0, (a[22:0] != 0 || !sign) ? 32'h7FFF_FFFF : 32'h8000_0000};
    n = {40'd0, (e8 != 0), a[22:0]};
    k = int'(e8) - 150;
    if (k >= 0) begin
      q    = (k > 30) ? 64'h1_0000_0000 : (n << k);
      rem  = 0;
      half = 1;
    end else if (k <= -40) begin
      q    = 0;
      rem  = {63'd0, n != 0};
      half = 64'd1 << 62;
    end else begin
      q    = n >> (-k);
      rem  = n - (q << (-k));
      half = 64'd1 << (-k - 1);
    end
    case (rm)
      2'd0:    up = (rem > half) || (rem == half && q[0]);
      2'd1:    up = 1'b0;
      2'd2:    up = !sign && rem != 0;
      default: up = sign && rem != 0;
    endcase
    q = q + {63'd0, up};
    if ((!sign && q > 64'h7FFF_FFFF) || (sign && q > 64'h8000_0000))
      return {1'b1, 1'b0, sign ? 32'h8000_0000 : 32'h7FFF_FFFF};
    r = sign ? (~q + 64'd1) : q;
    return {1'b0, rem != 0, r[31:0]};
  endfunction

  // scoreboard / compare process
  always @(negedge clk) begin
    logic [33:0] e;
    int          acc_edge;
    if (!rst_n) begin
      hold_v = 0;
    end else begin
      check("rdyin", {63'd0, rdyin}, {63'd0, !(vldout && !rdyout)});
      if (hold_v) begin
        check("hold_vld", {63'd0, vldout}, 64'd1);
        check("hold_data", {30'd0, invalid, inexact, dout}, {30'd0, hold_d});
      end
      if (vldin && rdyin) begin
        exp_q.push_back(model(ain, rmode));
        lat_q.push_back(cyc + 1);
      end
      if (vldout && rdyout) begin
        emit_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_out", {30'd0, invalid, inexact, dout}, 64'hDEAD_0000_0000_0000);
        end else begin
          e = exp_q.pop_front();
          acc_edge = lat_q.pop_front();
          check("result", {30'd0, invalid, inexact, dout}, {30'd0, e});
          if (lat_check) check("latency", 64'(cyc + 1 - acc_edge), 64'd3);
        end
      end
      hold_v = vldout && !rdyout;
      hold_d = {invalid, inexact, dout};
    end
  end

  // driver tasks
  task automatic send(input logic [31:0] a, input logic [1:0] m);
    int   n = 0;
    logic acc = 1'b0;
    vldin = 1'b1;
    ain   = a;
    rmode = m;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = rdyin;
      @(posedge clk);
      #1;
      n++;
    end
    check("send_accept", {63'd0, acc}, 64'd1);
    vldin = 1'b0;
  endtask

  task automatic idle(input int n);
    vldin = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    idle(2);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_vec(input logic [31:0] a, input logic [1:0] m, input logic [33:0] e);
    check("model_pin", {30'd0, model(a, m)}, {30'd0, e});
    send(a, m);
  endtask

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e8;
    logic [22:0] f;
    int          c;
    c = $urandom_range(0, 9);
    if (c == 0)      e8 = 8'd0;
    else if (c == 1) e8 = 8'd255;
    else if (c < 4)  e8 = 8'($urandom_range(150, 160));
    else             e8 = 8'($urandom_range(110, 160));
    f = ($urandom_range(0, 4) == 0) ? 23'd0 : 23'($urandom);
    return {1'($urandom_range(0, 1)), e8, f};
  endfunction

  logic [31:0] stream_tbl[10] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                                  32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000,
                                  32'h4110_0000, 32'h4120_0000};

  initial begin
    vldin = 1'b0;
    ain   = '0;
    rmode = '0;
    rdyout = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_vldout_during", {63'd0, vldout}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("reset_vldout", {63'd0, vldout}, 64'd0);
    check("reset_dout", {32'd0, dout}, 64'd0);
    check("reset_flags", {62'd0, invalid, inexact}, 64'd0);
    check("reset_rdyin", {63'd0, rdyin}, 64'd1);
    @(posedge clk);
    #1;

    // directed values with hand-computed expectations
    lat_check = 1;
    run_vec(32'h3FC0_0000, 2'd0, {2'b01, 32'd2});
    run_vec(32'h3FC0_0000, 2'd1, {2'b01, 32'd1});
    run_vec(32'h3FC0_0000, 2'd3, {2'b01, 32'd1});
    run_vec(32'h3FC0_0000, 2'd2, {2'b01, 32'd2});
    run_vec(32'h4020_0000, 2'd0, {2'b01, 32'd2});
    run_vec(32'hBFC0_0000, 2'd0, {2'b01, 32'hFFFF_FFFE});
    run_vec(32'hBFC0_0000, 2'd1, {2'b01, 32'hFFFF_FFFF});
    run_vec(32'h0000_0001, 2'd2, {2'b01, 32'd1});
    run_vec(32'h8000_0000, 2'd0, {2'b00, 32'd0});
    run_vec(32'hCF00_0000, 2'd0, {2'b00, 32'h8000_0000});
    run_vec(32'h4F00_0000, 2'd0, {2'b10, 32'h7FFF_FFFF});
    run_vec(32'hFF80_0000, 2'd0, {2'b10, 32'h8000_0000});
    run_vec(32'h7FC0_0000, 2'd0, {2'b10, 32'h7FFF_FFFF});
    run_vec(32'hFFC0_0000, 2'd3, {2'b10, 32'h7FFF_FFFF});
    run_vec(32'hBF00_0000, 2'd0, {2'b01, 32'd0});
    run_vec(32'h8000_0001, 2'd3, {2'b01, 32'hFFFF_FFFF});
    drain();

    // back-to-back stream 1.0 .. 10.0
    for (int i = 0; i < 10; i++)
      run_vec(stream_tbl[i], 2'd0, {2'b00, 32'(i + 1)});
    drain();

    // same stream with a 5-cycle downstream stall
    lat_check = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) send(stream_tbl[i], 2'd0);
      end
      begin
        repeat (4) begin
          @(posedge clk);
          #1;
        end
        rdyout = 1'b0;
        #1;
        check("stall_vldout", {63'd0, vldout}, 64'd1);
        check("stall_rdyin", {63'd0, rdyin}, 64'd0);
        repeat (5) @(posedge clk);
        #1;
        rdyout = 1'b1;
      end
    join
    drain();

    // reset with three words in flight
    send(32'h4160_0000, 2'd0);
    send(32'h4170_0000, 2'd0);
    send(32'h4180_0000, 2'd0);
    check("pre_reset_vldout", {63'd0, vldout}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("reset_mid_vldout", {63'd0, vldout}, 64'd0);
    exp_q.delete();
    lat_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    emit_cnt = 0;
    @(posedge clk);
    #1;
    lat_check = 1;
    send(32'h4190_0000, 2'd0);
    send(32'h41A0_0000, 2'd0);
    drain();
    check("post_reset_emits", 64'(emit_cnt), 64'd2);

    // randomized traffic with random back-pressure
    lat_check = 0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          send(rand_fp(), 2'($urandom_range(0, 3)));
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          rdyout = ($urandom_range(0, 3) != 0);
        end
        rdyout = 1'b1;
      end
    join
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
